// File: rtl/wb_grf_pkg.sv
// Shared pipeline definitions used by the write-back register file:
// write-data select encodings, fixed register numbers and instruction field positions.
package wb_grf_pkg;

  typedef enum logic [2:0] {
    WD_AO  = 3'd0,
    WD_RD  = 3'd1,
    WD_PC8 = 3'd2
  } wd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } grf_wr_t;

  // Read resolution shared by both ports: $0 is hard zero, a same-cycle
  // W-stage write to the same register is bypassed ahead of storage.
  function automatic logic [31:0] grf_read(input logic [4:0]  addr,
                                           input grf_wr_t     wr,
                                           input logic [31:0] stored);
    if (addr == REG_ZERO)                return '0;
    else if (wr.en && addr == wr.addr)   return wr.data;
    else                                 return stored;
  endfunction

endpackage

// File: rtl/wb_grf_if.sv
// W-stage write request, D-stage read ports and status outputs of the register file.
interface wb_grf_if;
  logic [31:0] W_PC;
  logic [31:0] W_I;
  logic        WE;
  logic        RegDst;
  logic        ra;
  logic [2:0]  WD_S;
  logic [31:0] W_AO;
  logic [31:0] W_RD;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic        W_WEN;
  logic [31:0] retire_cnt;

  modport master (
    output W_PC, W_I, WE, RegDst, ra, WD_S, W_AO, W_RD, A1, A2,
    input  RD1, RD2, W_A3, W_WD, W_WEN, retire_cnt
  );

  modport slave (
    input  W_PC, W_I, WE, RegDst, ra, WD_S, W_AO, W_RD, A1, A2,
    output RD1, RD2, W_A3, W_WD, W_WEN, retire_cnt
  );
endinterface

// File: rtl/wb_grf_bank.sv
// 31x32 register storage ($1..$31): one write port, two async read ports,
// async active-low clear. Address 0 reads as zero and is never stored.
module grf_bank
  import wb_grf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  grf_wr_t     wr_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] mem_q [1:31];

  for (genvar r = 1; r < 32; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                mem_q[r] <= '0;
      else if (wr_i.en && wr_i.addr == 5'(r))    mem_q[r] <= wr_i.data;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    for (int r = 1; r < 32; r++) begin
      if (ra1_i == 5'(r)) rd1_o = mem_q[r];
      if (ra2_i == 5'(r)) rd2_o = mem_q[r];
    end
  end

endmodule

// File: rtl/wb_grf.sv
// W-stage general register file: destination/data resolution, W->D bypass,
// retired-instruction counter and optional write trace around a grf_bank.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter bit          TRACE       = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [4:0]  rt, rd, a3;
  logic [31:0] wd;
  logic        wen;
  logic [31:0] rd1_st, rd2_st;
  logic [31:0] cnt_q, cnt_d;
  grf_wr_t     wr;

  assign rt = bus.W_I[RT_HI:RT_LO];
  assign rd = bus.W_I[RD_HI:RD_LO];

  // Link destination outranks RegDst.
  always_comb begin
    a3 = rt;
    if (bus.ra)          a3 = REG_RA;
    else if (bus.RegDst) a3 = rd;
  end

  always_comb begin
    wd = '0;
    case (wd_sel_e'(bus.WD_S))
      WD_AO:   wd = bus.W_AO;
      WD_RD:   wd = bus.W_RD;
      WD_PC8:  wd = bus.W_PC + LINK_OFFSET;
      default: wd = '0;
    endcase
  end

  // Gating with reset keeps the bypass and the trace quiet while held in reset.
  assign wen     = bus.WE & (a3 != REG_ZERO) & reset;
  assign wr.en   = wen;
  assign wr.addr = a3;
  assign wr.data = wd;

  grf_bank u_bank (
    .clk   (clk),
    .rst_n (reset),
    .wr_i  (wr),
    .ra1_i (bus.A1),
    .ra2_i (bus.A2),
    .rd1_o (rd1_st),
    .rd2_o (rd2_st)
  );

  assign bus.RD1   = grf_read(bus.A1, wr, rd1_st);
  assign bus.RD2   = grf_read(bus.A2, wr, rd2_st);
  assign bus.W_A3  = a3;
  assign bus.W_WD  = wd;
  assign bus.W_WEN = wen;

  // Any non-zero W-stage word is a real instruction; bubbles are all-zero.
  assign cnt_d = cnt_q + {31'd0, |bus.W_I};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.retire_cnt = cnt_q;

  if (TRACE) begin : g_trace
    always @(posedge clk) begin
      if (wen) $display("%d@%h: $%d <= %h", $time, bus.W_PC, a3, wd);
    end
  end

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 SHALL have parameter LINK_OFFSET, default 8, meaning byte offset added to W_PC for link writes.
REQ-002 SHALL have parameter TRACE, default 1, meaning write-log $display enabled when 1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port W_PC  input  32  PC of the instruction in W stage.
REQ-006 SHALL have port W_I  input  32  W-stage instruction word; rt = W_I[20:16], rd = W_I[15:11].
REQ-007 SHALL have port WE  input  1  W-stage register-write request.
REQ-008 SHALL have port RegDst  input  1  select rd as destination.
REQ-009 SHALL have port ra  input  1  select $31 as destination.
REQ-010 SHALL have port WD_S  input  3  write-data select.
REQ-011 SHALL have port W_AO  input  32  ALU result from W stage.
REQ-012 SHALL have port W_RD  input  32  memory read data from W stage.
REQ-013 SHALL have ports A1, A2  input  5  D-stage read addresses.
REQ-014 SHALL have ports RD1, RD2  output  32  D-stage read data.
REQ-015 SHALL have port W_A3  output  5  resolved write address, for the hazard/forward unit.
REQ-016 SHALL have port W_WD  output  32  resolved write data, for the hazard/forward unit.
REQ-017 SHALL have port W_WEN  output  1  effective write enable.
REQ-018 SHALL have port retire_cnt  output  32  count of retired non-bubble instructions.

Function
REQ-019 SHALL resolve W_A3: ra=1 -> 31; else RegDst=1 -> rd; else rt. ra has priority over RegDst.
REQ-020 SHALL resolve W_WD from WD_S: 0 -> W_AO; 1 -> W_RD; 2 -> W_PC+LINK_OFFSET (mod 2^32); 3..7 -> 0.
REQ-021 SHALL drive W_WEN = WE & (W_A3 != 0) & reset; when W_WEN=0, W_A3 and W_WD still show their resolved values.
REQ-022 SHALL write W_WD into register W_A3 on the rising clk edge when W_WEN=1; writes to $0 are discarded.
REQ-023 SHALL read combinationally: RDn = 0 if An=0; else W_WD if W_WEN=1 and An=W_A3 (internal W->D bypass); else stored value.
REQ-024 SHALL apply the bypass independently to both ports; A1=A2=W_A3 returns W_WD on both.
REQ-025 SHALL increment retire_cnt by 1 on each rising edge where W_I != 0; retire_cnt wraps from 0xFFFFFFFF to 0.
REQ-026 SHALL, when TRACE=1 and a write commits, $display "%d@%h: $%d <= %h" with $time, W_PC, W_A3, W_WD, exactly one line per committed write.
REQ-027 SHALL perform no write, log, or count on edges where W_WEN=0 (count still follows REQ-025).

Reset
REQ-028 SHALL, while reset=0, asynchronously clear registers $1..$31 and retire_cnt to 0; RD1/RD2 read 0; W_WEN=0.
REQ-029 SHALL let reset win over a simultaneous write edge: no write, no log, no count.
REQ-030 SHALL resume normal operation on the first rising edge after reset returns to 1, with no extra latency.

Structure
REQ-031 SHALL take from the shared pipeline package: WD_S encodings (WD_AO=0, WD_RD=1, WD_PC8=2), REG_RA=31, REG_ZERO=0, RT/RD field bit positions.
REQ-032 SHALL instantiate one sub-module, grf_bank: 31x32 storage with one write port, two async read ports, and async active-low clear. Address decode, data select, bypass, counter and trace SHALL sit in wb_grf.

Verification
REQ-033 SHALL cover: WE=1, RegDst=1, rd=5, WD_S=0, W_AO=0x1234 -> edge writes $5=0x1234; log "…@<PC>: $ 5 <= 00001234".
REQ-034 SHALL cover: WE=1, ra=1, RegDst=1, WD_S=2, W_PC=0x3000 -> $31=0x3008; W_A3=31.
REQ-035 SHALL cover: WE=1, rt=0, WD_S=1, W_RD=0xFFFFFFFF -> W_WEN=0, $0 reads 0, no log line.
REQ-036 SHALL cover: W_WEN=1, W_A3=7, W_WD=0xABCD, A1=A2=7 before the edge -> RD1=RD2=0xABCD in that cycle; stored old value is not returned.
REQ-037 SHALL cover: retire_cnt preloaded near wrap, with 3 non-zero W_I edges and 1 zero W_I edge -> advances 3 and wraps correctly.
REQ-038 SHALL cover: reset pulled low mid-cycle with W_WEN=1 -> all registers and retire_cnt read 0 immediately; no write at the next edge.
